// File: rtl/mac_tx_framer.sv
// Store-and-forward Ethernet transmit framer: buffers whole payload frames, then emits
// preamble, SFD, MAC header, payload, zero pad and CRC-32 FCS on GMII, followed by the IFG.
module mac_tx_framer #(
    parameter logic [47:0] P_SRC_MAC     = 48'h00_00_00_00_00_00,
    parameter int unsigned P_FIFO_DEPTH  = 4096,
    parameter int unsigned P_META_DEPTH  = 4,
    parameter int unsigned P_MAX_PAYLOAD = 1500,
    parameter int unsigned P_IFG         = 12
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [47:0] i_src_mac,
    input  logic        i_src_mac_valid,
    input  logic [47:0] i_up_dst_mac,
    input  logic [15:0] i_up_type,
    input  logic [7:0]  i_up_data,
    input  logic        i_up_last,
    input  logic        i_up_valid,
    output logic [7:0]  o_gmii_txd,
    output logic        o_gmii_tx_en,
    output logic        o_busy,
    output logic        o_drop
);

    localparam int unsigned DAW = $clog2(P_FIFO_DEPTH);
    localparam int unsigned MAW = $clog2(P_META_DEPTH);
    localparam logic [10:0] MAX_LEN  = 11'(P_MAX_PAYLOAD);
    localparam logic [10:0] MIN_LEN  = 11'd46;
    localparam logic [10:0] IFG_LAST = 11'(P_IFG - 1);
    localparam logic [DAW:0] DATA_DEPTH = (DAW + 1)'(P_FIFO_DEPTH);
    localparam logic [DAW:0] MAX_FREE   = (DAW + 1)'(P_MAX_PAYLOAD);
    localparam logic [MAW:0] META_DEPTH = (MAW + 1)'(P_META_DEPTH);

    typedef struct packed {
        logic [10:0] len;
        logic [47:0] dst;
        logic [15:0] etype;
        logic [47:0] src;
    } desc_t;

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_SFD, S_DST, S_SRC, S_TYPE, S_DATA, S_PAD, S_FCS, S_IFG
    } state_t;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int unsigned i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [7:0] mac_byte(input logic [47:0] v, input logic [2:0] k);
        return v[8 * (5 - int'(k)) +: 8];
    endfunction

    // ---------------- source MAC ----------------
    logic [47:0] src_mac;

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst)                src_mac <= P_SRC_MAC;
        else if (i_src_mac_valid) src_mac <= i_src_mac;

    // ---------------- FIFO storage ----------------
    logic [7:0]     data_mem [P_FIFO_DEPTH];
    logic [DAW-1:0] data_wp, data_rp;
    logic [DAW:0]   data_cnt, data_free;
    desc_t          meta_mem [P_META_DEPTH];
    logic [MAW-1:0] meta_wp, meta_rp;
    logic [MAW:0]   meta_cnt;
    logic           meta_full, meta_empty;

    assign data_free  = DATA_DEPTH - data_cnt;
    assign meta_full  = (meta_cnt == META_DEPTH);
    assign meta_empty = (meta_cnt == '0);

    // ---------------- ingress ----------------
    logic        mid, keep;
    logic [10:0] cnt;
    logic [47:0] hdr_dst, hdr_src;
    logic [15:0] hdr_type;
    logic        first, admit, keep_now, wr_en, push, drop_now;
    logic [10:0] cnt_base, len_new;
    desc_t       push_desc;

    // A single-beat frame has no registered header yet, so the descriptor takes it from the inputs.
    always_comb begin
        first     = i_up_valid && !mid;
        admit     = !meta_full && (data_free >= MAX_FREE);
        keep_now  = first ? admit : keep;
        cnt_base  = first ? '0 : cnt;
        wr_en     = i_up_valid && keep_now && (cnt_base < MAX_LEN);
        len_new   = cnt_base + 11'(wr_en);
        push      = i_up_valid && i_up_last && keep_now;
        drop_now  = first && !admit;
        push_desc.len   = len_new;
        push_desc.dst   = first ? i_up_dst_mac : hdr_dst;
        push_desc.etype = first ? i_up_type    : hdr_type;
        push_desc.src   = first ? src_mac      : hdr_src;
    end

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            mid      <= 1'b0;
            keep     <= 1'b0;
            cnt      <= '0;
            hdr_dst  <= '0;
            hdr_type <= '0;
            hdr_src  <= '0;
            o_drop   <= 1'b0;
        end else begin
            o_drop <= drop_now;
            if (i_up_valid) begin
                mid  <= !i_up_last;
                keep <= keep_now;
                cnt  <= len_new;
                if (first) begin
                    hdr_dst  <= i_up_dst_mac;
                    hdr_type <= i_up_type;
                    hdr_src  <= src_mac;
                end
            end
        end

    // ---------------- egress FSM ----------------
    state_t      state, state_n;
    logic [10:0] idx, idx_n;
    logic [31:0] crc, crc_n;
    desc_t       cur;
    logic        pop, rd_en, tx_en_n;
    logic [7:0]  txd_n;

    // Outputs are registered from the next state, so the wire shows the byte of the state being entered.
    always_comb begin
        state_n = state;
        idx_n   = idx + 11'd1;
        pop     = 1'b0;
        case (state)
            S_IDLE: begin
                idx_n = '0;
                if (!meta_empty) begin
                    pop     = 1'b1;
                    state_n = S_PRE;
                end
            end
            S_PRE:  if (idx == 11'd6) begin state_n = S_SFD; idx_n = '0; end
            S_SFD:  begin state_n = S_DST; idx_n = '0; end
            S_DST:  if (idx == 11'd5) begin state_n = S_SRC; idx_n = '0; end
            S_SRC:  if (idx == 11'd5) begin state_n = S_TYPE; idx_n = '0; end
            S_TYPE: if (idx == 11'd1) begin state_n = S_DATA; idx_n = '0; end
            S_DATA:
                if (idx == cur.len - 11'd1) begin
                    if (cur.len < MIN_LEN) state_n = S_PAD;
                    else begin state_n = S_FCS; idx_n = '0; end
                end
            S_PAD:  if (idx == MIN_LEN - 11'd1) begin state_n = S_FCS; idx_n = '0; end
            S_FCS:  if (idx == 11'd3) begin state_n = S_IFG; idx_n = '0; end
            S_IFG:
                if (idx == IFG_LAST) begin
                    idx_n = '0;
                    if (!meta_empty) begin
                        pop     = 1'b1;
                        state_n = S_PRE;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            default: begin state_n = S_IDLE; idx_n = '0; end
        endcase

        rd_en   = (state_n == S_DATA);
        tx_en_n = state_n inside {S_PRE, S_SFD, S_DST, S_SRC, S_TYPE, S_DATA, S_PAD, S_FCS};
        case (state_n)
            S_PRE:   txd_n = 8'h55;
            S_SFD:   txd_n = 8'hD5;
            S_DST:   txd_n = mac_byte(cur.dst, idx_n[2:0]);
            S_SRC:   txd_n = mac_byte(cur.src, idx_n[2:0]);
            S_TYPE:  txd_n = idx_n[0] ? cur.etype[7:0] : cur.etype[15:8];
            S_DATA:  txd_n = data_mem[data_rp];
            S_FCS:
                case (idx_n[1:0])
                    2'd0:    txd_n = ~crc[7:0];
                    2'd1:    txd_n = ~crc[15:8];
                    2'd2:    txd_n = ~crc[23:16];
                    default: txd_n = ~crc[31:24];
                endcase
            default: txd_n = 8'h00;
        endcase

        if (state_n == S_PRE)
            crc_n = '1;
        else if (state_n inside {S_DST, S_SRC, S_TYPE, S_DATA, S_PAD})
            crc_n = crc_step(crc, txd_n);
        else
            crc_n = crc;
    end

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            state        <= S_IDLE;
            idx          <= '0;
            crc          <= '1;
            cur          <= '0;
            o_gmii_txd   <= '0;
            o_gmii_tx_en <= 1'b0;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            crc          <= crc_n;
            o_gmii_txd   <= txd_n;
            o_gmii_tx_en <= tx_en_n;
            if (pop) cur <= meta_mem[meta_rp];
        end

    assign o_busy = (state != S_IDLE);

    // ---------------- FIFO pointers ----------------
    always_ff @(posedge i_clk) begin
        if (wr_en) data_mem[data_wp] <= i_up_data;
        if (push)  meta_mem[meta_wp] <= push_desc;
    end

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            data_wp  <= '0;
            data_rp  <= '0;
            data_cnt <= '0;
            meta_wp  <= '0;
            meta_rp  <= '0;
            meta_cnt <= '0;
        end else begin
            if (wr_en) data_wp <= data_wp + DAW'(1);
            if (rd_en) data_rp <= data_rp + DAW'(1);
            data_cnt <= data_cnt + (DAW + 1)'(wr_en) - (DAW + 1)'(rd_en);
            if (push)  meta_wp <= meta_wp + MAW'(1);
            if (pop)   meta_rp <= meta_rp + MAW'(1);
            meta_cnt <= meta_cnt + (MAW + 1)'(push) - (MAW + 1)'(pop);
        end

endmodule

// File: tb/tb_mac_tx_framer.sv
// Bench for mac_tx_framer: random payloads, expected GMII frames built from the framing rules
// with an MSB-first CRC-32 formulation, compared frame by frame against a passive monitor.
module tb_mac_tx_framer;

    localparam logic [47:0] SRC0 = 48'h00_0A_35_01_02_03;
    localparam int IFG  = 12;
    localparam int MAXP = 1500;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [47:0] i_src_mac;
    logic        i_src_mac_valid;
    logic [47:0] i_up_dst_mac;
    logic [15:0] i_up_type;
    logic [7:0]  i_up_data;
    logic        i_up_last;
    logic        i_up_valid;
    logic [7:0]  o_gmii_txd;
    logic        o_gmii_tx_en;
    logic        o_busy;
    logic        o_drop;

    always #4 i_clk = ~i_clk;

    mac_tx_framer #(
        .P_SRC_MAC    (SRC0),
        .P_FIFO_DEPTH (4096),
        .P_META_DEPTH (4),
        .P_MAX_PAYLOAD(MAXP),
        .P_IFG        (IFG)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_src_mac      (i_src_mac),
        .i_src_mac_valid(i_src_mac_valid),
        .i_up_dst_mac   (i_up_dst_mac),
        .i_up_type      (i_up_type),
        .i_up_data      (i_up_data),
        .i_up_last      (i_up_last),
        .i_up_valid     (i_up_valid),
        .o_gmii_txd     (o_gmii_txd),
        .o_gmii_tx_en   (o_gmii_tx_en),
        .o_busy         (o_busy),
        .o_drop         (o_drop)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    byte unsigned exp_bytes[$], rx_bytes[$];
    int exp_len[$], exp_gap[$], exp_start[$];
    int rx_len[$], rx_gap[$], rx_start[$];
    int drops = 0;
    int mac_at = -1;
    logic [47:0] mac_new = '0;

    // Passive monitor: assembles tx_en bursts into frames, measures the idle gap before each one.
    initial begin : monitor
        byte unsigned cur[$];
        bit in_tx;
        int idle_run, start, gap;
        in_tx = 0; idle_run = -1; start = 0; gap = -1;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                cur.delete(); in_tx = 0; idle_run = -1;
            end else if (o_gmii_tx_en) begin
                if (!in_tx) begin in_tx = 1; start = cyc; gap = idle_run; end
                cur.push_back(o_gmii_txd);
            end else if (in_tx) begin
                foreach (cur[i]) rx_bytes.push_back(cur[i]);
                rx_len.push_back(cur.size());
                rx_gap.push_back(gap);
                rx_start.push_back(start);
                cur.delete(); in_tx = 0; idle_run = 1;
            end else if (idle_run >= 0) begin
                idle_run++;
            end
            if (o_drop) drops++;
        end
    end

    task automatic check(input string tag, input longint obs, input longint expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drives one frame (contiguous beats) and, if requested, queues the frame expected on GMII.
    task automatic send_frame(input logic [47:0] dst, input logic [15:0] etype, input int n,
                              input logic [47:0] src, input bit expect_it, input int gap,
                              input bit timed);
        byte unsigned e[$];
        logic [7:0]  b;
        logic [31:0] c, r;
        logic        fb;
        for (int i = 0; i < 7; i++) e.push_back(8'h55);
        e.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) e.push_back(dst[8*i +: 8]);
        for (int i = 5; i >= 0; i--) e.push_back(src[8*i +: 8]);
        e.push_back(etype[15:8]);
        e.push_back(etype[7:0]);
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (i < MAXP) e.push_back(b);
            i_up_valid      = 1'b1;
            i_up_data       = b;
            i_up_last       = (i == n - 1);
            i_up_dst_mac    = dst;
            i_up_type       = etype;
            i_src_mac_valid = (i == mac_at);
            i_src_mac       = mac_new;
            @(posedge i_clk); #1;
        end
        i_up_valid = 1'b0; i_up_last = 1'b0; i_src_mac_valid = 1'b0;
        while (e.size() < 8 + 14 + 46) e.push_back(8'h00);
        // Non-reflected shift register fed LSB-first; the FCS is its bit-reversed complement.
        c = '1;
        for (int k = 8; k < e.size(); k++) begin
            b = e[k];
            for (int j = 0; j < 8; j++) begin
                fb = b[j] ^ c[31];
                c  = c << 1;
                if (fb) c = c ^ 32'h04C1_1DB7;
            end
        end
        for (int j = 0; j < 32; j++) r[j] = c[31 - j];
        r = ~r;
        for (int j = 0; j < 4; j++) e.push_back(r[8*j +: 8]);
        if (expect_it) begin
            foreach (e[i]) exp_bytes.push_back(e[i]);
            exp_len.push_back(e.size());
            exp_gap.push_back(gap);
            exp_start.push_back(timed ? cyc + 1 : -1);
        end
    endtask

    task automatic drain(input string name, input int budget);
        byte unsigned e[$], r[$];
        int t, el, rl, mism, g, rg, s, rs, nf;
        logic [31:0] fe, fr;
        t = 0; nf = 0;
        while (rx_len.size() < exp_len.size() && t < budget) begin @(posedge i_clk); t++; end
        repeat (IFG + 4) @(posedge i_clk);
        #1;
        check($sformatf("%s frame_count", name), rx_len.size(), exp_len.size());
        while (exp_len.size() > 0 && rx_len.size() > 0) begin
            el = exp_len.pop_front(); rl = rx_len.pop_front();
            e.delete(); r.delete();
            repeat (el) e.push_back(exp_bytes.pop_front());
            repeat (rl) r.push_back(rx_bytes.pop_front());
            check($sformatf("%s f%0d length", name, nf), rl, el);
            mism = 0;
            for (int i = 0; i < el - 4 && i < rl - 4; i++) if (e[i] !== r[i]) mism++;
            check($sformatf("%s f%0d byte_mismatches", name, nf), mism, 0);
            fe = {e[el-1], e[el-2], e[el-3], e[el-4]};
            fr = (rl >= 4) ? {r[rl-1], r[rl-2], r[rl-3], r[rl-4]} : 32'h0;
            check($sformatf("%s f%0d fcs", name, nf), fr, fe);
            g = exp_gap.pop_front(); rg = rx_gap.pop_front();
            if (g >= 0) check($sformatf("%s f%0d idle_gap", name, nf), rg, g);
            s = exp_start.pop_front(); rs = rx_start.pop_front();
            if (s >= 0) check($sformatf("%s f%0d start_cycle", name, nf), rs, s);
            nf++;
        end
        exp_bytes.delete(); exp_len.delete(); exp_gap.delete(); exp_start.delete();
        rx_bytes.delete(); rx_len.delete(); rx_gap.delete(); rx_start.delete();
    endtask

    initial begin : stimulus
        int d0, t;
        logic [47:0] m1, m2;
        i_rst = 1'b1; i_src_mac = '0; i_src_mac_valid = 1'b0;
        i_up_dst_mac = '0; i_up_type = '0; i_up_data = '0; i_up_last = 1'b0; i_up_valid = 1'b0;
        repeat (3) @(posedge i_clk); #1;
        check("reset txd", o_gmii_txd, 8'h00);
        check("reset tx_en", o_gmii_tx_en, 1'b0);
        check("reset busy", o_busy, 1'b0);
        check("reset drop", o_drop, 1'b0);
        i_rst = 1'b0;
        repeat (2) @(posedge i_clk); #1;

        // ARP broadcast, minimum payload; 0x55 two cycles after the last beat.
        send_frame(48'hFFFF_FFFF_FFFF, 16'h0806, 46, SRC0, 1, -1, 1);
        drain("arp46", 300);

        // Short payload gets zero pad.
        send_frame(48'({$urandom, $urandom}), 16'h0800, 10, SRC0, 1, -1, 1);
        drain("pad10", 300);

        // Back-to-back frames separated by exactly the IFG.
        send_frame(48'({$urandom, $urandom}), 16'h0800, 60, SRC0, 1, -1, 1);
        send_frame(48'({$urandom, $urandom}), 16'h0806, 60, SRC0, 1, IFG, 0);
        drain("b2b60", 500);

        // Oversize frame truncated to max payload, then five frames while it drains: fifth dropped.
        d0 = drops;
        send_frame(48'({$urandom, $urandom}), 16'h0800, 1600, SRC0, 1, -1, 1);
        check("oversize no_drop", drops - d0, 0);
        send_frame(48'({$urandom, $urandom}), 16'h0800, 1, SRC0, 1, IFG, 0);
        for (int k = 0; k < 3; k++)
            send_frame(48'({$urandom, $urandom}), 16'h0806, int'($urandom_range(2, 20)), SRC0, 1, IFG, 0);
        send_frame(48'({$urandom, $urandom}), 16'h0800, int'($urandom_range(2, 20)), SRC0, 0, -1, 0);
        repeat (3) @(posedge i_clk); #1;
        check("meta_full drop_pulses", drops - d0, 1);
        drain("oversize+queue", 3000);

        // MAC reload mid-ingress affects only the next frame.
        m1 = 48'({$urandom, $urandom});
        m2 = 48'({$urandom, $urandom});
        i_src_mac = m1; i_src_mac_valid = 1'b1;
        @(posedge i_clk); #1;
        i_src_mac_valid = 1'b0;
        mac_at = 10; mac_new = m2;
        send_frame(48'({$urandom, $urandom}), 16'h0800, 30, m1, 1, -1, 1);
        mac_at = -1;
        send_frame(48'({$urandom, $urandom}), 16'h0800, 20, m2, 1, -1, 0);
        drain("macswap", 500);

        // Asynchronous reset while transmitting payload.
        send_frame(48'({$urandom, $urandom}), 16'h0800, 300, m2, 0, -1, 0);
        t = 0;
        while (!o_gmii_tx_en && t < 100) begin @(posedge i_clk); #1; t++; end
        check("abort tx_en_seen", o_gmii_tx_en, 1'b1);
        repeat (40) @(posedge i_clk);
        #1;
        check("abort busy_before", o_busy, 1'b1);
        #2 i_rst = 1'b1;
        #1;
        check("abort async tx_en", o_gmii_tx_en, 1'b0);
        check("abort async txd", o_gmii_txd, 8'h00);
        check("abort async busy", o_busy, 1'b0);
        repeat (2) @(posedge i_clk); #1;
        i_rst = 1'b0;
        repeat (30) @(posedge i_clk); #1;
        check("post_reset idle", o_busy, 1'b0);
        check("post_reset no_frames", rx_len.size(), 0);
        send_frame(48'({$urandom, $urandom}), 16'h0806, 50, SRC0, 1, -1, 1);
        drain("post_reset", 300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
